fifo_stream_reader: RTL and testbench

//   Read-side engine for sync_fifo: drives rEn against the FIFO's empty flag,

---
 rtl/fifo_stream_reader.sv | 87 ++++++++
 tb/tb_fifo_stream_reader.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side engine for a synchronous FIFO. It issues reads against the FIFO empty flag,
// captures the returned data and presents it as a valid/ready stream.
module fifo_stream_reader #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              fifoEmpty,
    output logic              fifoREn,
    input  logic [DATA_W-1:0] fifoRData,
    output logic              oValid,
    input  logic              oReady,
    output logic [DATA_W-1:0] oData,
    input  logic              flush,
    output logic [CNT_W-1:0]  wordCnt
);

    logic [1:0]        occ_reg;
    logic [1:0]        occ_next;
    logic              in_flight_reg;
    logic              head_reg;
    logic              head_next;
    logic [DATA_W-1:0] buf_reg [2];
    logic [CNT_W-1:0]  word_cnt_reg;
    logic [CNT_W-1:0]  word_cnt_next;

    logic       pop;
    logic       push;
    logic       tail;
    logic [1:0] pending;

    assign pop  = (occ_reg != 2'd0) && oReady;
    assign push = in_flight_reg && !flush;
    // The tail slot is always free when a word lands, because occ + inFlight never exceeds 2.
    assign tail = head_reg ^ occ_reg[0];

    // This is the number of words still held after this cycle's pop, counting the word in flight.
    // The path from oReady to fifoREn is combinational on purpose so that one word per cycle is
    // reached.
    assign pending = occ_reg + {1'b0, in_flight_reg} - {1'b0, pop};
    assign fifoREn = arst_n && !fifoEmpty && !flush && (pending <= 2'd1);

    always_comb begin
        occ_next      = occ_reg;
        head_next     = head_reg;
        word_cnt_next = word_cnt_reg + {{(CNT_W-1){1'b0}}, pop};
        if (flush) begin
            occ_next  = 2'd0;
            head_next = 1'b0;
        end else begin
            occ_next  = occ_reg + {1'b0, push} - {1'b0, pop};
            head_next = head_reg ^ pop;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            occ_reg       <= 2'd0;
            in_flight_reg <= 1'b0;
            head_reg      <= 1'b0;
            word_cnt_reg  <= '0;
        end else begin
            occ_reg       <= occ_next;
            in_flight_reg <= fifoREn;
            head_reg      <= head_next;
            word_cnt_reg  <= word_cnt_next;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            always_ff @(posedge clk or negedge arst_n) begin
                if (!arst_n) begin
                    buf_reg[gi] <= '0;
                end else if (push && (tail == 1'(gi))) begin
                    buf_reg[gi] <= fifoRData;
                end
            end
        end
    endgenerate

    assign oValid  = (occ_reg != 2'd0);
    assign oData   = buf_reg[head_reg];
    assign wordCnt = word_cnt_reg;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader. A behavioural registered-empty FIFO feeds the reader, and a
// scoreboard queue is checked against every delivered word.
module tb_fifo_stream_reader;

    localparam int DW = 32;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          fifoEmpty;
    logic          fifoREn;
    logic [DW-1:0] fifoRData;
    logic          oValid;
    logic          oReady = 1'b0;
    logic [DW-1:0] oData;
    logic          flush = 1'b0;
    logic [CW-1:0] wordCnt;

    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;

    int            tests = 0;
    int            fails = 0;
    int            delivered = 0;
    int            wr_total = 0;
    bit            verbose = 1'b1;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] fq [$];

    always #5 clk = ~clk;

    fifo_stream_reader #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .fifoEmpty (fifoEmpty),
        .fifoREn   (fifoREn),
        .fifoRData (fifoRData),
        .oValid    (oValid),
        .oReady    (oReady),
        .oData     (oData),
        .flush     (flush),
        .wordCnt   (wordCnt)
    );

    // FIFO model: the empty flag is registered and the read data arrives the cycle after fifoREn.
    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            fq.delete();
            fifoEmpty <= 1'b1;
            fifoRData <= '0;
        end else begin
            if (fifoREn && fq.size() != 0) fifoRData <= fq.pop_front();
            if (wr_en) fq.push_back(wr_data);
            fifoEmpty <= (fq.size() == 0);
        end
    end

    // Stream monitor: scoreboard, hold-while-stalled and no-read-while-empty checks
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [DW-1:0] exp_word;
    always @(negedge clk) begin
        if (!arst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (fifoREn) begin
                tests++;
                if (fifoEmpty) begin
                    fails++;
                    $display("FAIL ren_while_empty: fifoREn=1 with fifoEmpty=%0b, required no read", fifoEmpty);
                end
            end
            if (prev_stall) begin
                tests++;
                if (oValid !== 1'b1 || oData !== prev_data) begin
                    fails++;
                    $display("FAIL stall_hold: oValid=%0b oData=%h, required 1 and %h", oValid, oData, prev_data);
                end
            end
            if (oValid && oReady) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL scoreboard_extra: got %h, required no word", oData);
                end else begin
                    exp_word = exp_q.pop_front();
                    if (oData !== exp_word) begin
                        fails++;
                        $display("FAIL scoreboard: got %h, required %h", oData, exp_word);
                    end else if (verbose) begin
                        $display("[TB] word %h delivered", oData);
                    end
                end
                delivered++;
            end
            prev_stall = oValid && !oReady && !flush;
            prev_data  = oData;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Loads n words into the FIFO while flush keeps the reader idle. The flush stays asserted
    // when the task returns.
    task automatic preload(input int n, input logic [DW-1:0] base);
        flush = 1'b1;
        for (int i = 0; i < n; i++) begin
            next_cycle();
            wr_en   = 1'b1;
            wr_data = base + DW'(i);
            exp_q.push_back(wr_data);
            wr_total++;
        end
        next_cycle();
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || oValid) && c < limit) begin
            next_cycle();
            c++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (oValid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b, required 0", oValid); end
        tests++;
        if (fifoREn !== 1'b0) begin fails++; $display("FAIL reset_ren: got %b, required 0", fifoREn); end
        tests++;
        if (wordCnt !== '0) begin fails++; $display("FAIL reset_cnt: got %0d, required 0", wordCnt); end
        tests++;
        if (oData !== '0) begin fails++; $display("FAIL reset_data: got %h, required 0", oData); end
        next_cycle();
        arst_n = 1'b1;
        delivered = 0;
        wr_total = 0;
        next_cycle();
    endtask

    task automatic test_single();
        oReady = 1'b1;
        next_cycle();
        wr_en = 1'b1;
        wr_data = 32'hA5A5_0001;
        exp_q.push_back(wr_data);
        wr_total++;
        next_cycle();
        wr_en = 1'b0;
        @(negedge clk);
        tests++;
        if (fifoREn !== 1'b1) begin fails++; $display("FAIL single_ren_n: got %b, required 1", fifoREn); end
        @(negedge clk);
        tests++;
        if (fifoREn !== 1'b0 || oValid !== 1'b0) begin
            fails++; $display("FAIL single_n1: ren=%b valid=%b, required 0 0", fifoREn, oValid);
        end
        @(negedge clk);
        tests++;
        if (oValid !== 1'b1 || oData !== 32'hA5A5_0001) begin
            fails++; $display("FAIL single_n2: valid=%b data=%h, required 1 a5a50001", oValid, oData);
        end
        @(negedge clk);
        tests++;
        if (oValid !== 1'b0) begin fails++; $display("FAIL single_n3: valid=%b, required 0", oValid); end
        tests++;
        if (wordCnt !== CW'(1)) begin fails++; $display("FAIL single_cnt: got %0d, required 1", wordCnt); end
    endtask

    task automatic test_streaming(input int n);
        int ren_cnt, ren_first, ren_last, val_cnt, val_first, val_last;
        int cnt_before;
        ren_cnt = 0; ren_first = -1; ren_last = -1;
        val_cnt = 0; val_first = -1; val_last = -1;
        cnt_before = delivered;
        verbose = 1'b0;
        preload(n, 32'h1000_0000);
        flush  = 1'b0;
        oReady = 1'b1;
        for (int c = 0; c < n + 10; c++) begin
            @(negedge clk);
            if (fifoREn) begin
                ren_cnt++;
                if (ren_first < 0) ren_first = c;
                ren_last = c;
            end
            if (oValid) begin
                val_cnt++;
                if (val_first < 0) val_first = c;
                val_last = c;
            end
        end
        tests++;
        if (ren_cnt != n || ren_first != 0 || ren_last != n - 1) begin
            fails++; $display("FAIL stream_ren: cnt=%0d first=%0d last=%0d, required %0d 0 %0d", ren_cnt, ren_first, ren_last, n, n - 1);
        end
        tests++;
        if (val_cnt != n || val_first != 2 || val_last != n + 1) begin
            fails++; $display("FAIL stream_valid: cnt=%0d first=%0d last=%0d, required %0d 2 %0d", val_cnt, val_first, val_last, n, n + 1);
        end
        tests++;
        if (wordCnt !== CW'(cnt_before + n)) begin
            fails++; $display("FAIL stream_cnt: got %0d, required %0d", wordCnt, CW'(cnt_before + n));
        end
        verbose = 1'b1;
    endtask

    task automatic test_backpressure();
        int ren_cnt;
        int cnt_before;
        ren_cnt = 0;
        cnt_before = delivered;
        oReady = 1'b0;
        preload(8, 32'h0000_00B0);
        flush = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (fifoREn) ren_cnt++;
            if (c >= 2) begin
                tests++;
                if (oValid !== 1'b1 || oData !== 32'h0000_00B0) begin
                    fails++; $display("FAIL bp_hold: valid=%b data=%h, required 1 000000b0", oValid, oData);
                end
            end
        end
        tests++;
        if (ren_cnt != 2) begin fails++; $display("FAIL bp_reads: got %0d, required 2", ren_cnt); end
        next_cycle();
        oReady = 1'b1;
        wait_drain(60);
        tests++;
        if (wordCnt !== CW'(cnt_before + 8)) begin
            fails++; $display("FAIL bp_cnt: got %0d, required %0d", wordCnt, CW'(cnt_before + 8));
        end
    endtask

    task automatic test_flush();
        int cnt_before;
        int c;
        oReady = 1'b0;
        preload(8, 32'h0000_00C0);
        flush = 1'b0;
        repeat (5) next_cycle();
        oReady = 1'b1;              // w0 is popped while w2 is read
        next_cycle();
        oReady = 1'b0;
        flush  = 1'b1;              // w1 is buffered and w2 is in flight; both are dropped
        cnt_before = delivered;
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        @(negedge clk);
        tests++;
        if (fifoREn !== 1'b0) begin fails++; $display("FAIL flush_ren: got %b, required 0", fifoREn); end
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        tests++;
        if (oValid !== 1'b0) begin fails++; $display("FAIL flush_valid: got %b, required 0", oValid); end
        tests++;
        if (wordCnt !== CW'(cnt_before)) begin
            fails++; $display("FAIL flush_cnt: got %0d, required %0d", wordCnt, CW'(cnt_before));
        end
        c = 0;
        while (!oValid && c < 10) begin
            @(negedge clk);
            c++;
        end
        tests++;
        if (oValid !== 1'b1 || oData !== 32'h0000_00C3) begin
            fails++; $display("FAIL flush_next: valid=%b data=%h, required 1 000000c3", oValid, oData);
        end
        next_cycle();
        oReady = 1'b1;
        wait_drain(60);
    endtask

    task automatic test_reset_mid();
        oReady = 1'b1;
        preload(20, 32'h0000_0D00);
        flush = 1'b0;
        repeat (6) next_cycle();
        arst_n = 1'b0;
        #1;
        tests++;
        if (oValid !== 1'b0 || fifoREn !== 1'b0 || wordCnt !== '0) begin
            fails++; $display("FAIL rst_mid: valid=%b ren=%b cnt=%0d, required 0 0 0", oValid, fifoREn, wordCnt);
        end
        exp_q.delete();
        delivered = 0;
        wr_total  = 0;
        repeat (2) next_cycle();
        arst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            wr_en   = 1'b1;
            wr_data = 32'h0000_0E00 + DW'(i);
            exp_q.push_back(wr_data);
            wr_total++;
        end
        next_cycle();
        wr_en = 1'b0;
        wait_drain(40);
        tests++;
        if (wordCnt !== CW'(5)) begin fails++; $display("FAIL rst_post_cnt: got %0d, required 5", wordCnt); end
    endtask

    task automatic test_random();
        int pct;
        verbose = 1'b0;
        for (int ph = 0; ph < 2; ph++) begin
            pct = (ph == 0) ? 25 : 50;
            for (int i = 0; i < 1500; i++) begin
                next_cycle();
                wr_en = ($urandom_range(0, 99) < pct);
                wr_data = $urandom;
                if (wr_en) begin
                    exp_q.push_back(wr_data);
                    wr_total++;
                end
                oReady = $urandom_range(0, 1) == 1;
            end
        end
        next_cycle();
        wr_en  = 1'b0;
        oReady = 1'b1;
        wait_drain(100);
        tests++;
        if (wordCnt !== CW'(wr_total)) begin
            fails++; $display("FAIL rand_cnt: got %0d, required %0d", wordCnt, CW'(wr_total));
        end
        verbose = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_streaming(1000);
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
